alu_sequencer: RTL and testbench
================================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 The block SHALL have these ports, one per line:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- cmd_valid  input  1  command offered.
- cmd_ready  output  1  command accepted when high with cmd_valid.
- cmd_mode  input  1  0 = arithmetic, 1 = logic (ALU mode encoding).
- cmd_select  input  4  ALU select code.
- cmd_wide  input  1  1 = 32-bit operation, 0 = 16-bit.
- cmd_carry_in  input  1  carry/borrow in for ADC (2) and SBB (3).
- cmd_a, cmd_b  input  32  operands; narrow ops use bits [15:0].
- alu_carry_in  output  1  to ALU carry_in.
- alu_in_a, alu_in_b  output  16  to ALU in_a, in_b.
- alu_select  output  4  to ALU select.
- alu_mode  output  1  to ALU mode.
- alu_out  input  16  from ALU.
- alu_carry_out  input  1  from ALU.
- alu_compare  input  1  from ALU; ignored.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  result consumed when high with rsp_valid.
- rsp_data  output  32  result; narrow ops zero-extended.
- rsp_carry  output  1  final carry/borrow; 0 in logic mode.
- rsp_zero  output  1  rsp_data == 0.
- op_count  output  16  completed responses, wraps 0xFFFF -> 0x0000.

Function
REQ-002 The block SHALL implement the states IDLE, LO, HI and RESP.
REQ-003 cmd_ready SHALL be 1 only in IDLE; a command SHALL be latched on the edge where cmd_valid && cmd_ready, with transition to LO.
REQ-004 In LO the ALU drives SHALL be: a[15:0], b[15:0], cmd_mode, and a low-half select.
- Narrow: select = cmd_select, carry_in = cmd_carry_in.
- Wide arithmetic: 0->0 (carry_in 0), 1->1 (carry_in 0), 2->2 and 3->3 (carry_in = cmd_carry_in).
REQ-005 At the end of LO the block SHALL capture alu_out into result[15:0] and alu_carry_out into an internal carry register.
REQ-006 LO SHALL go to RESP if cmd_wide = 0, otherwise to HI.
REQ-007 In HI the ALU drives SHALL be: a[31:16] and b[31:16].
- Arithmetic select 0 or 2 drives 2 (ADC); select 1 or 3 drives 3 (SBB); carry_in = captured low carry.
- Arithmetic select > 3 drives select unchanged, carry_in 0.
- Logic mode drives the same select, carry_in 0.
REQ-008 At the end of HI the block SHALL capture alu_out into result[31:16] and the final carry, then go to RESP.
REQ-009 Wide logic shifts SHALL cross the halves:
- Select 7 (shift left): result[16] = a[15].
- Select 8 (shift right): result[15] = a[16].
REQ-010 Outside LO/HI every alu_* output SHALL be 0.
REQ-011 In RESP, rsp_valid SHALL be 1 and rsp_data/rsp_carry/rsp_zero SHALL be held stable until the edge where rsp_ready = 1; that edge SHALL return the block to IDLE and increment op_count.
REQ-012 Latency SHALL be measured from the accept edge to rsp_valid high: narrow 2 cycles, wide 3 cycles; the minimum command interval SHALL be 3 cycles (narrow) and 4 cycles (wide).
REQ-013 rsp_carry SHALL be 0 in logic mode and for arithmetic select > 3; for subtract it SHALL be 1 on borrow.
REQ-014 rsp_zero SHALL be computed over all 32 bits of rsp_data, independent of alu_compare.
REQ-015 cmd_* changes outside the accept edge SHALL have no effect on an operation in progress.

Reset
REQ-016 While rst_n = 0: state = IDLE, cmd_ready = 0, rsp_valid = 0, rsp_data = 0, rsp_carry = 0, rsp_zero = 0, op_count = 0, all alu_* outputs = 0.
REQ-017 Reset asserted in LO, HI or RESP SHALL abort the operation with no response.
REQ-018 cmd_ready SHALL rise in the first cycle after rst_n deasserts.

Verification
REQ-019 Narrow add: 0x0000FFFF + 0x00000001, select 0 -> rsp_data 0x00000000, rsp_carry 1, rsp_zero 1, rsp_valid 2 cycles after accept.
REQ-020 Wide add: 0x0000FFFF + 0x00000001 -> HI drives select 2 with carry_in 1; result 0x00010000, carry 0, zero 0, rsp_valid 3 cycles after accept.
REQ-021 Wide sub:
- 0x00000000 - 0x00000001 -> 0xFFFFFFFF, carry 1.
- 0x00010000 - 0x00000001 -> 0x0000FFFF, carry 0.
REQ-022 Wide logic shift left of 0x00008000 -> 0x00010000; wide shift right of 0x00010000 -> 0x00008000.
REQ-023 Backpressure: rsp_ready held low 5 cycles with cmd_valid high -> rsp_data stable, cmd_ready 0, no second accept, op_count increments once on release.
REQ-024 rst_n pulsed low during HI -> rsp_valid never rises for that command, all outputs zero, cmd_ready 1 one cycle after release, op_count 0.

Source files
------------

// File: rtl/alu_sequencer.sv
// Sequences 16- and 32-bit operations through an external 16-bit ALU.
// A wide op runs the low half then the high half, chaining the carry.
module alu_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_mode,
    input  logic [3:0]  cmd_select,
    input  logic        cmd_wide,
    input  logic        cmd_carry_in,
    input  logic [31:0] cmd_a,
    input  logic [31:0] cmd_b,
    output logic        alu_carry_in,
    output logic [15:0] alu_in_a,
    output logic [15:0] alu_in_b,
    output logic [3:0]  alu_select,
    output logic        alu_mode,
    input  logic [15:0] alu_out,
    input  logic        alu_carry_out,
    input  logic        alu_compare,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_carry,
    output logic        rsp_zero,
    output logic [15:0] op_count
);

    typedef enum logic [1:0] {IDLE, LO, HI, RESP} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic        r_mode;
    logic [3:0]  r_sel;
    logic        r_wide;
    logic        r_cin;
    logic [31:0] r_result;
    logic        r_carry;
    logic        r_live;
    logic [15:0] r_count;
    logic        w_arith_ok;
    logic [15:0] w_hi;
    logic        w_lo15;
    logic        w_unused;

    assign w_unused   = alu_compare;
    // Only ADD/SUB/ADC/SBB produce a meaningful carry or borrow
    assign w_arith_ok = !r_mode && (r_sel <= 4'd3);

    assign cmd_ready = (r_state == IDLE) && r_live;
    assign rsp_valid = (r_state == RESP);
    assign rsp_data  = rsp_valid ? r_result : 32'h0;
    assign rsp_carry = rsp_valid && r_carry;
    assign rsp_zero  = rsp_valid && (r_result == 32'h0);
    assign op_count  = r_count;

    always_comb begin
        w_next       = r_state;
        alu_in_a     = 16'h0;
        alu_in_b     = 16'h0;
        alu_select   = 4'h0;
        alu_mode     = 1'b0;
        alu_carry_in = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (cmd_valid && cmd_ready) w_next = LO;
            end
            LO: begin
                alu_in_a   = r_a[15:0];
                alu_in_b   = r_b[15:0];
                alu_mode   = r_mode;
                alu_select = r_sel;
                if (!r_wide)
                    alu_carry_in = r_cin;
                else if (w_arith_ok)
                    alu_carry_in = r_sel[1] & r_cin;
                w_next = r_wide ? HI : RESP;
            end
            HI: begin
                alu_in_a = r_a[31:16];
                alu_in_b = r_b[31:16];
                alu_mode = r_mode;
                if (w_arith_ok) begin
                    alu_select   = {3'b001, r_sel[0]};
                    alu_carry_in = r_carry;
                end else begin
                    alu_select = r_sel;
                end
                w_next = RESP;
            end
            RESP: begin
                if (rsp_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Wide logic shifts carry the bit that crosses the half boundary
    always_comb begin
        w_hi   = alu_out;
        w_lo15 = r_result[15];
        if (r_mode && r_sel == 4'd7) w_hi[0] = r_a[15];
        if (r_mode && r_sel == 4'd8) w_lo15 = r_a[16];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_a      <= 32'h0;
            r_b      <= 32'h0;
            r_mode   <= 1'b0;
            r_sel    <= 4'h0;
            r_wide   <= 1'b0;
            r_cin    <= 1'b0;
            r_result <= 32'h0;
            r_carry  <= 1'b0;
            r_live   <= 1'b0;
            r_count  <= 16'h0;
        end else begin
            r_state <= w_next;
            r_live  <= 1'b1;
            if (r_state == IDLE && cmd_valid && cmd_ready) begin
                r_a    <= cmd_a;
                r_b    <= cmd_b;
                r_mode <= cmd_mode;
                r_sel  <= cmd_select;
                r_wide <= cmd_wide;
                r_cin  <= cmd_carry_in;
            end
            if (r_state == LO) begin
                r_result <= {16'h0, alu_out};
                r_carry  <= alu_carry_out & w_arith_ok;
            end
            if (r_state == HI) begin
                r_result <= {w_hi, w_lo15, r_result[14:0]};
                r_carry  <= alu_carry_out & w_arith_ok;
            end
            if (r_state == RESP && rsp_ready)
                r_count <= r_count + 16'h1;
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural 16-bit ALU model.
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_mode;
    logic [3:0]  cmd_select;
    logic        cmd_wide;
    logic        cmd_carry_in;
    logic [31:0] cmd_a;
    logic [31:0] cmd_b;
    logic        alu_carry_in;
    logic [15:0] alu_in_a;
    logic [15:0] alu_in_b;
    logic [3:0]  alu_select;
    logic        alu_mode;
    logic [15:0] alu_out;
    logic        alu_carry_out;
    logic        alu_compare;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_carry;
    logic        rsp_zero;
    logic [15:0] op_count;

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    alu_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_mode(cmd_mode), .cmd_select(cmd_select),
        .cmd_wide(cmd_wide), .cmd_carry_in(cmd_carry_in),
        .cmd_a(cmd_a), .cmd_b(cmd_b),
        .alu_carry_in(alu_carry_in), .alu_in_a(alu_in_a),
        .alu_in_b(alu_in_b), .alu_select(alu_select),
        .alu_mode(alu_mode), .alu_out(alu_out),
        .alu_carry_out(alu_carry_out), .alu_compare(alu_compare),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_carry(rsp_carry),
        .rsp_zero(rsp_zero), .op_count(op_count)
    );

    // ALU model: arith 0 ADD, 1 SUB, 2 ADC, 3 SBB; logic 7 SHL, 8 SHR
    always_comb begin
        alu_out       = alu_in_a;
        alu_carry_out = 1'b1;
        alu_compare   = (alu_in_a == alu_in_b);
        if (!alu_mode) begin
            case (alu_select)
                4'd0: {alu_carry_out, alu_out} =
                    {1'b0, alu_in_a} + {1'b0, alu_in_b};
                4'd1: {alu_carry_out, alu_out} =
                    {1'b0, alu_in_a} - {1'b0, alu_in_b};
                4'd2: {alu_carry_out, alu_out} =
                    {1'b0, alu_in_a} + {1'b0, alu_in_b}
                    + {16'h0, alu_carry_in};
                4'd3: {alu_carry_out, alu_out} =
                    {1'b0, alu_in_a} - {1'b0, alu_in_b}
                    - {16'h0, alu_carry_in};
                default: ;
            endcase
        end else begin
            case (alu_select)
                4'd0: alu_out = ~alu_in_a;
                4'd1: alu_out = alu_in_a & alu_in_b;
                4'd2: alu_out = alu_in_a | alu_in_b;
                4'd3: alu_out = alu_in_a ^ alu_in_b;
                4'd7: begin
                    alu_out       = {alu_in_a[14:0], 1'b0};
                    alu_carry_out = alu_in_a[15];
                end
                4'd8: begin
                    alu_out       = {1'b0, alu_in_a[15:1]};
                    alu_carry_out = alu_in_a[0];
                end
                default: ;
            endcase
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic run_cmd(
        input  logic        m,
        input  logic [3:0]  s,
        input  logic        w,
        input  logic        ci,
        input  logic [31:0] a,
        input  logic [31:0] b,
        output int          lat,
        output logic [33:0] res,
        output logic [3:0]  hsel,
        output logic        hcin
    );
        @(negedge clk);
        cmd_mode = m; cmd_select = s; cmd_wide = w;
        cmd_carry_in = ci; cmd_a = a; cmd_b = b;
        cmd_valid = 1'b1; rsp_ready = 1'b0;
        lat = -1; res = '0; hsel = 4'h0; hcin = 1'b0;
        for (int i = 0; i < 20 && !cmd_ready; i++) @(negedge clk);
        if (cmd_ready) begin
            for (int k = 1; k <= 8; k++) begin
                @(negedge clk);
                cmd_valid = 1'b0;
                if (k == 1) begin
                    cmd_a = ~a; cmd_b = ~b; cmd_select = ~s;
                    cmd_mode = ~m; cmd_wide = ~w; cmd_carry_in = ~ci;
                end
                if (k == 2) begin
                    hsel = alu_select; hcin = alu_carry_in;
                end
                if (rsp_valid) begin
                    lat = k;
                    res = {rsp_data, rsp_carry, rsp_zero};
                    break;
                end
            end
        end
        cmd_valid = 1'b0;
        if (lat > 0) begin
            rsp_ready = 1'b1;
            @(negedge clk);
            rsp_ready = 1'b0;
            exp_cnt++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
        cmd_mode = 1'b0; cmd_select = 4'h0; cmd_wide = 1'b0;
        cmd_carry_in = 1'b0; cmd_a = 32'h0; cmd_b = 32'h0;
        repeat (3) @(negedge clk);
        checks++;
        if ({cmd_ready, rsp_valid, rsp_data, rsp_carry, rsp_zero,
             op_count} !== '0) begin
            errors++;
            $display("FAIL reset_out got rdy=%b v=%b d=%h c=%b z=%b n=%h",
                     cmd_ready, rsp_valid, rsp_data, rsp_carry,
                     rsp_zero, op_count);
        end
        checks++;
        if ({alu_carry_in, alu_in_a, alu_in_b, alu_select,
             alu_mode} !== '0) begin
            errors++;
            $display("FAIL reset_alu got a=%h b=%h s=%h m=%b ci=%b want 0",
                     alu_in_a, alu_in_b, alu_select, alu_mode,
                     alu_carry_in);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got %b want 1", cmd_ready);
        end
    endtask

    task automatic test_narrow();
        int lat; logic [33:0] r; logic [3:0] hs; logic hc;
        run_cmd(0, 4'd0, 0, 0, 32'h0000FFFF, 32'h00000001, lat, r, hs, hc);
        checks++;
        if (lat !== 2) begin
            errors++; $display("FAIL nadd_lat got %0d want 2", lat);
        end
        checks++;
        if (r !== {32'h0, 1'b1, 1'b1}) begin
            errors++; $display("FAIL nadd_res got %h want %h", r,
                               {32'h0, 1'b1, 1'b1});
        end
        run_cmd(0, 4'd1, 0, 0, 32'h12340005, 32'hABCD0007, lat, r, hs, hc);
        checks++;
        if (r !== {32'h0000FFFE, 1'b1, 1'b0}) begin
            errors++; $display("FAIL nsub_res got %h want %h", r,
                               {32'h0000FFFE, 1'b1, 1'b0});
        end
        run_cmd(0, 4'd5, 0, 1, 32'h00001234, 32'h00000001, lat, r, hs, hc);
        checks++;
        if (r !== {32'h00001234, 1'b0, 1'b0}) begin
            errors++; $display("FAIL nsel5_res got %h want %h", r,
                               {32'h00001234, 1'b0, 1'b0});
        end
        run_cmd(1, 4'd1, 0, 1, 32'h0000F0F0, 32'h00000FF0, lat, r, hs, hc);
        checks++;
        if (r !== {32'h000000F0, 1'b0, 1'b0}) begin
            errors++; $display("FAIL nand_res got %h want %h", r,
                               {32'h000000F0, 1'b0, 1'b0});
        end
    endtask

    task automatic test_wide_arith();
        int lat; logic [33:0] r; logic [3:0] hs; logic hc;
        run_cmd(0, 4'd0, 1, 0, 32'h0000FFFF, 32'h00000001, lat, r, hs, hc);
        checks++;
        if (lat !== 3) begin
            errors++; $display("FAIL wadd_lat got %0d want 3", lat);
        end
        checks++;
        if ({hs, hc} !== {4'd2, 1'b1}) begin
            errors++; $display("FAIL wadd_hi got sel=%0d ci=%b want 2 1",
                               hs, hc);
        end
        checks++;
        if (r !== {32'h00010000, 1'b0, 1'b0}) begin
            errors++; $display("FAIL wadd_res got %h want %h", r,
                               {32'h00010000, 1'b0, 1'b0});
        end
        run_cmd(0, 4'd1, 1, 0, 32'h00000000, 32'h00000001, lat, r, hs, hc);
        checks++;
        if (r !== {32'hFFFFFFFF, 1'b1, 1'b0}) begin
            errors++; $display("FAIL wsub1_res got %h want %h", r,
                               {32'hFFFFFFFF, 1'b1, 1'b0});
        end
        run_cmd(0, 4'd1, 1, 0, 32'h00010000, 32'h00000001, lat, r, hs, hc);
        checks++;
        if ({hs, r} !== {4'd3, 32'h0000FFFF, 1'b0, 1'b0}) begin
            errors++; $display("FAIL wsub2 got sel=%0d res=%h want 3 %h",
                               hs, r, {32'h0000FFFF, 1'b0, 1'b0});
        end
        run_cmd(0, 4'd2, 1, 1, 32'hFFFFFFFF, 32'h00000000, lat, r, hs, hc);
        checks++;
        if (r !== {32'h00000000, 1'b1, 1'b1}) begin
            errors++; $display("FAIL wadc_res got %h want %h", r,
                               {32'h00000000, 1'b1, 1'b1});
        end
    endtask

    task automatic test_wide_logic();
        int lat; logic [33:0] r; logic [3:0] hs; logic hc;
        run_cmd(1, 4'd7, 1, 0, 32'h00008000, 32'h0, lat, r, hs, hc);
        checks++;
        if (r !== {32'h00010000, 1'b0, 1'b0}) begin
            errors++; $display("FAIL wshl_res got %h want %h", r,
                               {32'h00010000, 1'b0, 1'b0});
        end
        run_cmd(1, 4'd8, 1, 0, 32'h00010000, 32'h0, lat, r, hs, hc);
        checks++;
        if (r !== {32'h00008000, 1'b0, 1'b0}) begin
            errors++; $display("FAIL wshr_res got %h want %h", r,
                               {32'h00008000, 1'b0, 1'b0});
        end
        run_cmd(1, 4'd3, 1, 1, 32'h12345678, 32'hFFFF0000, lat, r, hs, hc);
        checks++;
        if ({hs, hc, r} !== {4'd3, 1'b0, 32'hEDCB5678, 1'b0, 1'b0}) begin
            errors++; $display("FAIL wxor got sel=%0d ci=%b res=%h",
                               hs, hc, r);
        end
        checks++;
        if ({alu_carry_in, alu_in_a, alu_in_b, alu_select, alu_mode,
             rsp_valid} !== '0 || op_count !== exp_cnt[15:0]) begin
            errors++; $display("FAIL idle_out got s=%h v=%b n=%0d want 0 0 %0d",
                               alu_select, rsp_valid, op_count, exp_cnt);
        end
    endtask

    task automatic test_backpressure();
        int n;
        @(negedge clk);
        cmd_mode = 0; cmd_select = 4'd0; cmd_wide = 0; cmd_carry_in = 0;
        cmd_a = 32'h3; cmd_b = 32'h4; cmd_valid = 1'b1; rsp_ready = 1'b0;
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(negedge clk); n++;
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({rsp_valid, cmd_ready, rsp_data} !== {1'b1, 1'b0, 32'h7}) begin
                errors++; $display("FAIL bp_hold%0d got v=%b rdy=%b d=%h want 1 0 7",
                                   i, rsp_valid, cmd_ready, rsp_data);
            end
            @(negedge clk);
        end
        checks++;
        if (op_count !== exp_cnt[15:0]) begin
            errors++; $display("FAIL bp_cnt_pre got %0d want %0d",
                               op_count, exp_cnt);
        end
        cmd_valid = 1'b0; rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        exp_cnt++;
        checks++;
        if ({op_count, rsp_valid} !== {exp_cnt[15:0], 1'b0}) begin
            errors++; $display("FAIL bp_cnt got %0d v=%b want %0d 0",
                               op_count, rsp_valid, exp_cnt);
        end
    endtask

    task automatic test_back_to_back(input logic w, input int gap);
        int first, second, acc;
        @(negedge clk);
        cmd_mode = 0; cmd_select = 4'd0; cmd_wide = w; cmd_carry_in = 0;
        cmd_a = 32'h1; cmd_b = 32'h1; cmd_valid = 1'b1; rsp_ready = 1'b1;
        first = -1; second = -1; acc = 0;
        for (int c = 0; c < 12; c++) begin
            if (cmd_valid && cmd_ready) begin
                acc++;
                if (first < 0) first = c;
                else if (second < 0) second = c;
            end
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        repeat (5) @(negedge clk);
        rsp_ready = 1'b0;
        exp_cnt += acc;
        checks++;
        if (second - first !== gap || first < 0) begin
            errors++; $display("FAIL b2b_gap w=%b got %0d want %0d",
                               w, second - first, gap);
        end
        checks++;
        if (op_count !== exp_cnt[15:0]) begin
            errors++; $display("FAIL b2b_cnt got %0d want %0d",
                               op_count, exp_cnt);
        end
    endtask

    task automatic test_reset_in_hi();
        @(negedge clk);
        cmd_mode = 0; cmd_select = 4'd0; cmd_wide = 1; cmd_carry_in = 0;
        cmd_a = 32'h0000FFFF; cmd_b = 32'h1; cmd_valid = 1'b1;
        rsp_ready = 1'b1;
        for (int i = 0; i < 20 && !cmd_ready; i++) @(negedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({alu_select, alu_carry_in} !== {4'd2, 1'b1}) begin
            errors++; $display("FAIL rhi_state got sel=%0d ci=%b want 2 1",
                               alu_select, alu_carry_in);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({cmd_ready, rsp_valid, rsp_data, rsp_carry, rsp_zero, op_count,
             alu_carry_in, alu_in_a, alu_in_b, alu_select,
             alu_mode} !== '0) begin
            errors++; $display("FAIL rhi_zero got v=%b n=%0d a=%h s=%h",
                               rsp_valid, op_count, alu_in_a, alu_select);
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp_cnt = 0;
        @(negedge clk);
        checks++;
        if ({cmd_ready, rsp_valid, op_count} !== {1'b1, 1'b0, 16'h0}) begin
            errors++; $display("FAIL rhi_after got rdy=%b v=%b n=%0d want 1 0 0",
                               cmd_ready, rsp_valid, op_count);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b0) begin
                errors++; $display("FAIL rhi_norsp%0d got %b want 0",
                                   i, rsp_valid);
            end
        end
        rsp_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_narrow();
        test_wide_arith();
        test_wide_logic();
        test_backpressure();
        test_back_to_back(1'b0, 3);
        test_back_to_back(1'b1, 4);
        test_reset_in_hi();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
